// File: rtl/master_spi4nano.sv
`default_nettype none
// ============================================================================
// Module      : master_spi4nano
// Description : SPI master (mode 0, MSB first) for the Nano programming port.
//               Sends one 40-bit frame {cmd, addr, data} per request and
//               captures the last 16 MISO bits for read operations.
//               Optional macro NANO_SPIM_ERR_EN adds a sticky 'err' output
//               that flags any start seen while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module master_spi4nano #(
    parameter int DIV     = 4,
    parameter int GAP_CYC = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [11:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic        SPI_CS,
    output logic        SPI_SCK,
    output logic        SPI_MOSI,
    input  logic        SPI_MISO
`ifdef NANO_SPIM_ERR_EN
    ,
    output logic        err
`endif
);

    localparam int CW = $clog2(DIV) + 1;
    localparam int GW = $clog2(GAP_CYC) + 1;
    localparam logic [CW-1:0] C_HMAX = CW'(DIV - 1);
    localparam logic [GW-1:0] C_GMAX = GW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [5:0]    bit_q, bit_d;
    logic          last_q, last_d;
    logic [39:0]   shreg_q, shreg_d;
    logic [15:0]   rx_q, rx_d;
    logic [1:0]    op_q, op_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          cs_q, cs_d;
    logic          sck_q, sck_d;
    logic [15:0]   w_data_field;

    // Data field placed on MOSI: full word for data writes, low byte for code writes, zeros for reads
    always_comb begin
        case (op)
            2'b10:   w_data_field = wdata;
            2'b00:   w_data_field = {8'h00, wdata[7:0]};
            default: w_data_field = 16'h0000;
        endcase
    end

    // Next-state and output logic of the frame sequencer
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        gcnt_d  = gcnt_q;
        bit_d   = bit_q;
        last_d  = last_q;
        shreg_d = shreg_q;
        rx_d    = rx_q;
        op_d    = op_q;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cs_d    = cs_q;
        sck_d   = sck_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETUP;
                    shreg_d = {op, 6'b0, 4'b0, addr, w_data_field};
                    op_d    = op;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    hcnt_d  = '0;
                    bit_d   = '0;
                    last_d  = 1'b0;
                end
            end
            S_SETUP: begin
                if (hcnt_q == C_HMAX) begin
                    // first rising SCK edge; slave already presents bit 39
                    hcnt_d  = '0;
                    sck_d   = 1'b1;
                    rx_d    = {rx_q[14:0], SPI_MISO};
                    state_d = S_SHIFT;
                end else begin
                    hcnt_d = hcnt_q + CW'(1);
                end
            end
            S_SHIFT: begin
                if (hcnt_q == C_HMAX) begin
                    hcnt_d = '0;
                    if (sck_q) begin
                        sck_d = 1'b0;
                        if (bit_q == 6'd39) begin
                            // last bit stays on MOSI through the final low phase and HOLD
                            last_d = 1'b1;
                        end else begin
                            bit_d   = bit_q + 6'd1;
                            shreg_d = {shreg_q[38:0], 1'b0};
                        end
                    end else if (last_q) begin
                        state_d = S_HOLD;
                    end else begin
                        sck_d = 1'b1;
                        rx_d  = {rx_q[14:0], SPI_MISO};
                    end
                end else begin
                    hcnt_d = hcnt_q + CW'(1);
                end
            end
            S_HOLD: begin
                if (hcnt_q == C_HMAX) begin
                    hcnt_d  = '0;
                    gcnt_d  = '0;
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    shreg_d = '0;
                    state_d = S_GAP;
                    if (op_q[0]) begin
                        rdata_d = op_q[1] ? rx_q : {8'h00, rx_q[7:0]};
                    end
                end else begin
                    hcnt_d = hcnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (gcnt_q == C_GMAX) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_d    = 1'b1;
                sck_d   = 1'b0;
                busy_d  = 1'b0;
                shreg_d = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            hcnt_q  <= '0;
            gcnt_q  <= '0;
            bit_q   <= '0;
            last_q  <= 1'b0;
            shreg_q <= '0;
            rx_q    <= '0;
            op_q    <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            gcnt_q  <= gcnt_d;
            bit_q   <= bit_d;
            last_q  <= last_d;
            shreg_q <= shreg_d;
            rx_q    <= rx_d;
            op_q    <= op_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
        end
    end

`ifdef NANO_SPIM_ERR_EN
    logic err_q, err_d;

    // Sticky flag for requests arriving while a frame or gap is in progress
    always_comb begin
        err_d = err_q | (start & busy_q);
    end

    // Error flag register, cleared only by reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign SPI_CS   = cs_q;
    assign SPI_SCK  = sck_q;
    assign SPI_MOSI = shreg_q[39];

endmodule
`default_nettype wire

// File: tb/tb_master_spi4nano.sv
`default_nettype none
// ============================================================================
// Module      : tb_master_spi4nano
// Description : Directed self-checking bench for master_spi4nano with a
//               mode-0 slave model per instance (DIV=4 and DIV=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_master_spi4nano;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST = 1'b1;
    logic        start4 = 1'b0, start1 = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [11:0] addr = 12'h000;
    logic [15:0] wdata = 16'h0000;

    logic        busy4, done4, cs4, sck4, mosi4, miso4;
    logic        busy1, done1, cs1, sck1, mosi1, miso1;
    logic [15:0] rdata4, rdata1;
`ifdef NANO_SPIM_ERR_EN
    logic        err4, err1;
`endif

    logic [39:0] resp4 = '0, resp1 = '0;
    int tests = 0;
    int fails = 0;

    master_spi4nano #(.DIV(4), .GAP_CYC(8)) u4 (
        .CLK(CLK), .RST(RST), .start(start4), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy4), .done(done4), .rdata(rdata4),
        .SPI_CS(cs4), .SPI_SCK(sck4), .SPI_MOSI(mosi4), .SPI_MISO(miso4)
`ifdef NANO_SPIM_ERR_EN
        , .err(err4)
`endif
    );

    master_spi4nano #(.DIV(1), .GAP_CYC(8)) u1 (
        .CLK(CLK), .RST(RST), .start(start1), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy1), .done(done1), .rdata(rdata1),
        .SPI_CS(cs1), .SPI_SCK(sck1), .SPI_MOSI(mosi1), .SPI_MISO(miso1)
`ifdef NANO_SPIM_ERR_EN
        , .err(err1)
`endif
    );

    // Slave model and bus monitor for the DIV=4 instance
    logic [39:0] cap4 = '0;
    int rise4 = 0, cslow4 = 0, hirun4 = 0, lasthi4 = 0, donecnt4 = 0, idx4 = 0;
    logic pcs4 = 1'b1, psck4 = 1'b0;
    always @(negedge CLK) begin
        if (!cs4 && pcs4) begin
            cap4 <= '0; rise4 <= 0; cslow4 <= 1; lasthi4 <= hirun4;
        end else begin
            if (!cs4) cslow4 <= cslow4 + 1;
            if (sck4 && !psck4) begin cap4 <= {cap4[38:0], mosi4}; rise4 <= rise4 + 1; end
        end
        if (cs4) hirun4 <= pcs4 ? hirun4 + 1 : 1;
        if (cs4) idx4 <= 0; else if (!sck4 && psck4) idx4 <= idx4 + 1;
        if (done4) donecnt4 <= donecnt4 + 1;
        pcs4 <= cs4; psck4 <= sck4;
    end
    assign miso4 = (idx4 < 40) ? resp4[6'(39 - idx4)] : 1'b0;

    // Slave model and bus monitor for the DIV=1 instance
    logic [39:0] cap1 = '0;
    int rise1 = 0, cslow1 = 0, donecnt1 = 0, idx1 = 0;
    logic pcs1 = 1'b1, psck1 = 1'b0;
    always @(negedge CLK) begin
        if (!cs1 && pcs1) begin
            cap1 <= '0; rise1 <= 0; cslow1 <= 1;
        end else begin
            if (!cs1) cslow1 <= cslow1 + 1;
            if (sck1 && !psck1) begin cap1 <= {cap1[38:0], mosi1}; rise1 <= rise1 + 1; end
        end
        if (cs1) idx1 <= 0; else if (!sck1 && psck1) idx1 <= idx1 + 1;
        if (done1) donecnt1 <= donecnt1 + 1;
        pcs1 <= cs1; psck1 <= sck1;
    end
    assign miso1 = (idx1 < 40) ? resp1[6'(39 - idx1)] : 1'b0;

    task automatic pulse_start4();
        @(posedge CLK); #1 start4 = 1'b1;
        @(posedge CLK); #1 start4 = 1'b0;
    endtask

    task automatic wait_done4(output bit got);
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK);
            if (done4) begin got = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        tests++; if (cs4 !== 1'b1 || sck4 !== 1'b0 || mosi4 !== 1'b0) begin fails++;
            $display("FAIL reset_bus4: cs=%b sck=%b mosi=%b required 1 0 0", cs4, sck4, mosi4); end
        tests++; if (busy4 !== 1'b0 || done4 !== 1'b0 || rdata4 !== 16'h0000) begin fails++;
            $display("FAIL reset_status4: busy=%b done=%b rdata=%h required 0 0 0000", busy4, done4, rdata4); end
        tests++; if (cs1 !== 1'b1 || busy1 !== 1'b0 || rdata1 !== 16'h0000) begin fails++;
            $display("FAIL reset_div1: cs=%b busy=%b rdata=%h required 1 0 0000", cs1, busy1, rdata1); end
        // start coinciding with reset must not launch a frame
        start4 = 1'b1;
        @(posedge CLK); #1 RST = 1'b0; start4 = 1'b0;
        repeat (3) @(negedge CLK);
        tests++; if (cs4 !== 1'b1 || busy4 !== 1'b0) begin fails++;
            $display("FAIL start_with_rst: cs=%b busy=%b required 1 0", cs4, busy4); end
    endtask

    task automatic test_read_code();
        bit got;
        resp4 = {24'h000000, 16'hFF5C};
        op = 2'b01; addr = 12'h07F; wdata = 16'h1234;
        pulse_start4();
        wait_done4(got);
        tests++; if (!got) begin fails++; $display("FAIL rcode_done: no done within bound"); end
        tests++; if (rdata4 !== 16'h005C) begin fails++;
            $display("FAIL rcode_rdata: got %h required 005c", rdata4); end
        tests++; if (cap4[39:32] !== 8'h40) begin fails++;
            $display("FAIL rcode_cmd: got %h required 40", cap4[39:32]); end
        tests++; if (cap4 !== 40'h40_007F_0000) begin fails++;
            $display("FAIL rcode_mosi: got %h required 40007f0000", cap4); end
        tests++; if (cslow4 !== 328) begin fails++;
            $display("FAIL rcode_cslow: got %0d required 328", cslow4); end
        repeat (12) @(negedge CLK);
    endtask

    task automatic test_write_data();
        bit got;
        int d0;
        d0 = donecnt4;
        op = 2'b10; addr = 12'h02A; wdata = 16'hBEEF;
        pulse_start4();
        repeat (50) @(posedge CLK);
        // a request during the frame must be ignored and must not touch latched fields
        #1 op = 2'b01; addr = 12'hFFF; wdata = 16'h0000; start4 = 1'b1;
        @(posedge CLK); #1 start4 = 1'b0;
        wait_done4(got);
        tests++; if (!got) begin fails++; $display("FAIL wdata_done: no done within bound"); end
        tests++; if (busy4 !== 1'b1 || cs4 !== 1'b1) begin fails++;
            $display("FAIL wdata_at_done: busy=%b cs=%b required 1 1", busy4, cs4); end
        tests++; if (cap4 !== 40'h80_002A_BEEF) begin fails++;
            $display("FAIL wdata_mosi: got %h required 80002abeef", cap4); end
        tests++; if (cslow4 !== 328) begin fails++;
            $display("FAIL wdata_cslow: got %0d required 328", cslow4); end
        repeat (12) @(negedge CLK);
        tests++; if (rdata4 !== 16'h005C) begin fails++;
            $display("FAIL wdata_rdata_hold: got %h required 005c", rdata4); end
        tests++; if (donecnt4 - d0 !== 1) begin fails++;
            $display("FAIL wdata_done_count: got %0d required 1", donecnt4 - d0); end
        tests++; if (busy4 !== 1'b0 || cs4 !== 1'b1) begin fails++;
            $display("FAIL wdata_idle: busy=%b cs=%b required 0 1", busy4, cs4); end
    endtask

    task automatic test_back_to_back();
        bit got;
        op = 2'b00; addr = 12'h055; wdata = 16'hAB12;
        @(posedge CLK); #1 start4 = 1'b1;
        wait_done4(got);
        tests++; if (!got) begin fails++; $display("FAIL b2b_done1: no done within bound"); end
        @(negedge CLK);
        wait_done4(got);
        start4 = 1'b0;
        tests++; if (!got) begin fails++; $display("FAIL b2b_done2: no done within bound"); end
        tests++; if (lasthi4 !== 9) begin fails++;
            $display("FAIL b2b_gap: got %0d cs-high cycles required 9", lasthi4); end
        tests++; if (cap4 !== 40'h00_0055_0012) begin fails++;
            $display("FAIL b2b_mosi: got %h required 0000550012", cap4); end
        tests++; if (cslow4 !== 328) begin fails++;
            $display("FAIL b2b_cslow: got %0d required 328", cslow4); end
        repeat (20) @(negedge CLK);
        tests++; if (busy4 !== 1'b0 || cs4 !== 1'b1) begin fails++;
            $display("FAIL b2b_stop: busy=%b cs=%b required 0 1", busy4, cs4); end
    endtask

    task automatic test_reset_mid();
        bit got;
        int d0;
        resp4 = {24'h000000, 16'h1234};
        op = 2'b11; addr = 12'h123; wdata = 16'h0000;
        pulse_start4();
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK);
            if (rise4 >= 20) begin got = 1'b1; break; end
        end
        tests++; if (!got) begin fails++; $display("FAIL rmid_bit20: bit 20 not reached within bound"); end
        d0 = donecnt4;
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1;
        tests++; if (cs4 !== 1'b1 || sck4 !== 1'b0 || mosi4 !== 1'b0) begin fails++;
            $display("FAIL rmid_bus: cs=%b sck=%b mosi=%b required 1 0 0", cs4, sck4, mosi4); end
        tests++; if (busy4 !== 1'b0 || done4 !== 1'b0 || rdata4 !== 16'h0000) begin fails++;
            $display("FAIL rmid_status: busy=%b done=%b rdata=%h required 0 0 0000", busy4, done4, rdata4); end
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        tests++; if (donecnt4 !== d0 || cs4 !== 1'b1) begin fails++;
            $display("FAIL rmid_no_done: done pulses %0d cs=%b required 0 1", donecnt4 - d0, cs4); end
        pulse_start4();
        wait_done4(got);
        tests++; if (!got) begin fails++; $display("FAIL rmid_refr_done: no done within bound"); end
        tests++; if (rdata4 !== 16'h1234 || cap4 !== 40'hC0_0123_0000) begin fails++;
            $display("FAIL rmid_reframe: rdata=%h mosi=%h required 1234 c001230000", rdata4, cap4); end
        repeat (12) @(negedge CLK);
    endtask

    task automatic test_div1();
        bit got;
        resp1 = {24'h000000, 16'hA55A};
        op = 2'b11; addr = 12'hFFF; wdata = 16'h0000;
        @(posedge CLK); #1 start1 = 1'b1;
        @(posedge CLK); #1 start1 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (done1) begin got = 1'b1; break; end
        end
        tests++; if (!got) begin fails++; $display("FAIL div1_done: no done within bound"); end
        tests++; if (rdata1 !== 16'hA55A) begin fails++;
            $display("FAIL div1_rdata: got %h required a55a", rdata1); end
        tests++; if (cslow1 !== 82) begin fails++;
            $display("FAIL div1_cslow: got %0d required 82", cslow1); end
        tests++; if (cap1 !== 40'hC0_0FFF_0000 || rise1 !== 40) begin fails++;
            $display("FAIL div1_mosi: got %h edges %0d required c00fff0000 40", cap1, rise1); end
        repeat (12) @(negedge CLK);
    endtask

`ifdef NANO_SPIM_ERR_EN
    task automatic test_err();
        bit got;
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        tests++; if (err4 !== 1'b0) begin fails++; $display("FAIL err_reset: got %b required 0", err4); end
        op = 2'b10; addr = 12'h02A; wdata = 16'hBEEF;
        pulse_start4();
        repeat (40) @(posedge CLK);
        #1 start4 = 1'b1;
        @(posedge CLK); #1 start4 = 1'b0;
        @(negedge CLK);
        tests++; if (err4 !== 1'b1) begin fails++; $display("FAIL err_set: got %b required 1", err4); end
        wait_done4(got);
        tests++; if (!got || err4 !== 1'b1 || cap4 !== 40'h80_002A_BEEF) begin fails++;
            $display("FAIL err_frame: done=%b err=%b mosi=%h required 1 1 80002abeef", got, err4, cap4); end
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        tests++; if (err4 !== 1'b0) begin fails++; $display("FAIL err_clear: got %b required 0", err4); end
    endtask
`endif

    initial begin
        test_reset();
        test_read_code();
        test_write_data();
        test_back_to_back();
        test_reset_mid();
        test_div1();
`ifdef NANO_SPIM_ERR_EN
        test_err();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
